// File: rtl/jtkunio_gfxrom_pkg.sv
// Shared types and helpers for the kunio graphics ROM fetcher.
package jtkunio_gfxrom_pkg;

   localparam int unsigned SDRAM_AW = 22;
   localparam int unsigned DW       = 32;
   localparam int unsigned MAX_AW   = 18;

   typedef enum logic [1:0] {
      CH_CHAR = 2'd0,
      CH_SCR  = 2'd1,
      CH_OBJ  = 2'd2
   } ch_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_e;

   // Fetch in flight: which slot it fills and the 32-bit word index it was issued for
   typedef struct packed {
      ch_e               ch;
      logic [MAX_AW-1:0] addr;
   } fetch_t;

   // 32-bit word index to SDRAM 16-bit word address, wrapping modulo 2^22
   function automatic logic [SDRAM_AW-1:0] rom_addr(
      input logic [SDRAM_AW-1:0] offset,
      input logic [MAX_AW-1:0]   idx
   );
      return offset + SDRAM_AW'({idx, 1'b0});
   endfunction

   function automatic ch_e ch_next(input ch_e c);
      case (c)
         CH_CHAR: return CH_SCR;
         CH_SCR:  return CH_OBJ;
         default: return CH_CHAR;
      endcase
   endfunction

endpackage

// File: rtl/jtkunio_gfxrom_slot.sv
// One-entry cache line for a single graphics channel; hit_c compares the live address.
module jtkunio_gfxrom_slot
   import jtkunio_gfxrom_pkg::*;
#(
   parameter int unsigned AW = 14
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] addr,
   input  logic          wr,
   input  logic [AW-1:0] wr_tag,
   input  logic [DW-1:0] wr_dat,
   output logic [DW-1:0] data,
   output logic          hit_c
);

   logic [AW-1:0] tag;
   logic          valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         tag   <= '0;
         data  <= '0;
         valid <= 1'b0;
      end else if (wr) begin
         tag   <= wr_tag;
         data  <= wr_dat;
         valid <= 1'b1;
      end
   end

   assign hit_c = valid && (tag == addr);

endmodule

// File: rtl/jtkunio_gfxrom.sv
// Char/scroll/object tile ROM fetcher sharing one SDRAM read bank, round-robin on misses.
// Optional JTKUNIO_GFXROM_STATS_EN adds a saturating stall cycle counter (stall_cnt).
module jtkunio_gfxrom
   import jtkunio_gfxrom_pkg::*;
#(
   parameter logic [SDRAM_AW-1:0] CHAR_OFFSET = 22'h00000,
   parameter logic [SDRAM_AW-1:0] SCR_OFFSET  = 22'h08000,
   parameter logic [SDRAM_AW-1:0] OBJ_OFFSET  = 22'h48000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [13:0]         char_addr,
   output logic [DW-1:0]       char_data,
   output logic                char_ok,
   input  logic [16:0]         scr_addr,
   output logic [DW-1:0]       scr_data,
   output logic                scr_ok,
   input  logic [17:0]         obj_addr,
   input  logic                obj_cs,
   output logic [DW-1:0]       obj_data,
   output logic                obj_ok,
   output logic [SDRAM_AW-1:0] sdram_addr,
   output logic                sdram_req,
   input  logic                sdram_ack,
   input  logic                sdram_rdy,
   input  logic [DW-1:0]       sdram_din
`ifdef JTKUNIO_GFXROM_STATS_EN
   ,
   output logic [15:0]         stall_cnt
`endif
);

   state_e              state, state_nxt;
   ch_e                 ptr, ptr_nxt;
   fetch_t              lat, lat_nxt;
   logic                req_nxt;
   logic [SDRAM_AW-1:0] addr_nxt;
   logic                fill_c;
   logic                char_hit_c, scr_hit_c, obj_hit_c;
   logic [2:0]          miss_c;
   ch_e                 win_c, cand1_c, cand2_c;
   logic [MAX_AW-1:0]   win_idx_c;
   logic [SDRAM_AW-1:0] win_sdram_c;

   jtkunio_gfxrom_slot #(.AW(14)) u_char (
      .clk    (clk),
      .rst    (rst),
      .addr   (char_addr),
      .wr     (fill_c && lat.ch == CH_CHAR),
      .wr_tag (lat.addr[13:0]),
      .wr_dat (sdram_din),
      .data   (char_data),
      .hit_c  (char_hit_c)
   );

   jtkunio_gfxrom_slot #(.AW(17)) u_scr (
      .clk    (clk),
      .rst    (rst),
      .addr   (scr_addr),
      .wr     (fill_c && lat.ch == CH_SCR),
      .wr_tag (lat.addr[16:0]),
      .wr_dat (sdram_din),
      .data   (scr_data),
      .hit_c  (scr_hit_c)
   );

   jtkunio_gfxrom_slot #(.AW(18)) u_obj (
      .clk    (clk),
      .rst    (rst),
      .addr   (obj_addr),
      .wr     (fill_c && lat.ch == CH_OBJ),
      .wr_tag (lat.addr),
      .wr_dat (sdram_din),
      .data   (obj_data),
      .hit_c  (obj_hit_c)
   );

   assign char_ok = char_hit_c;
   assign scr_ok  = scr_hit_c;
   assign obj_ok  = obj_hit_c && obj_cs;
   assign miss_c  = {obj_cs && !obj_hit_c, !scr_hit_c, !char_hit_c};

   // Round-robin pick starting at ptr, plus the winner's SDRAM address
   always_comb begin
      cand1_c = ch_next(ptr);
      cand2_c = ch_next(cand1_c);
      win_c   = ptr;
      if (!miss_c[ptr]) begin
         if (miss_c[cand1_c]) win_c = cand1_c;
         else                 win_c = cand2_c;
      end
      case (win_c)
         CH_CHAR: begin
            win_idx_c   = MAX_AW'(char_addr);
            win_sdram_c = rom_addr(CHAR_OFFSET, win_idx_c);
         end
         CH_SCR: begin
            win_idx_c   = MAX_AW'(scr_addr);
            win_sdram_c = rom_addr(SCR_OFFSET, win_idx_c);
         end
         default: begin
            win_idx_c   = obj_addr;
            win_sdram_c = rom_addr(OBJ_OFFSET, win_idx_c);
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ptr        <= CH_CHAR;
         lat        <= '0;
         sdram_req  <= 1'b0;
         sdram_addr <= '0;
      end else begin
         state      <= state_nxt;
         ptr        <= ptr_nxt;
         lat        <= lat_nxt;
         sdram_req  <= req_nxt;
         sdram_addr <= addr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|miss_c)   state_nxt = REQ;
         REQ:     if (sdram_ack) state_nxt = WAIT;
         WAIT:    if (sdram_rdy) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // rdy is only meaningful in WAIT; a stray one in IDLE/REQ is dropped
   always_comb begin
      req_nxt  = sdram_req;
      addr_nxt = sdram_addr;
      lat_nxt  = lat;
      ptr_nxt  = ptr;
      fill_c   = 1'b0;
      case (state)
         IDLE: begin
            if (|miss_c) begin
               req_nxt  = 1'b1;
               addr_nxt = win_sdram_c;
               lat_nxt  = '{ch: win_c, addr: win_idx_c};
            end
         end
         REQ: begin
            if (sdram_ack) req_nxt = 1'b0;
         end
         WAIT: begin
            if (sdram_rdy) begin
               fill_c  = 1'b1;
               ptr_nxt = ch_next(lat.ch);
            end
         end
         default: req_nxt = 1'b0;
      endcase
   end

`ifdef JTKUNIO_GFXROM_STATS_EN
   always_ff @(posedge clk) begin
      if (rst)                            stall_cnt <= '0;
      else if (|miss_c && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_jtkunio_gfxrom.sv
// Directed + randomized bench for jtkunio_gfxrom with a slot/round-robin reference model.
module tb_jtkunio_gfxrom;

   localparam logic [21:0] CHAR_OFF = 22'h00000;
   localparam logic [21:0] SCR_OFF  = 22'h08000;
   localparam logic [21:0] OBJ_OFF  = 22'h48000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [13:0] char_addr = '0;
   logic [16:0] scr_addr  = '0;
   logic [17:0] obj_addr  = '0;
   logic        obj_cs    = 1'b0;
   logic [31:0] char_data, scr_data, obj_data;
   logic        char_ok, scr_ok, obj_ok;
   logic [21:0] sdram_addr;
   logic        sdram_req;
   logic        sdram_ack = 1'b0;
   logic        sdram_rdy = 1'b0;
   logic [31:0] sdram_din = '0;
`ifdef JTKUNIO_GFXROM_STATS_EN
   logic [15:0] stall_cnt;
`endif

   always #5 clk = ~clk;

   jtkunio_gfxrom #(
      .CHAR_OFFSET (CHAR_OFF),
      .SCR_OFFSET  (SCR_OFF),
      .OBJ_OFFSET  (OBJ_OFF)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .char_addr  (char_addr),
      .char_data  (char_data),
      .char_ok    (char_ok),
      .scr_addr   (scr_addr),
      .scr_data   (scr_data),
      .scr_ok     (scr_ok),
      .obj_addr   (obj_addr),
      .obj_cs     (obj_cs),
      .obj_data   (obj_data),
      .obj_ok     (obj_ok),
      .sdram_addr (sdram_addr),
      .sdram_req  (sdram_req),
      .sdram_ack  (sdram_ack),
      .sdram_rdy  (sdram_rdy),
      .sdram_din  (sdram_din)
`ifdef JTKUNIO_GFXROM_STATS_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   int n_pass = 0;
   int n_chk  = 0;

   // Reference model: what each channel's cache holds and who was served last
   logic        m_valid [3];
   logic [17:0] m_tag   [3];
   logic [31:0] m_dat   [3];
   int          m_last;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", name, obs, exp);
   endtask

   task automatic m_reset();
      for (int c = 0; c < 3; c++) begin
         m_valid[c] = 1'b0;
         m_tag[c]   = '0;
         m_dat[c]   = '0;
      end
      m_last = 2;
   endtask

   function automatic logic [17:0] cur_addr(input int c);
      if (c == 0)      return 18'(char_addr);
      else if (c == 1) return 18'(scr_addr);
      else             return obj_addr;
   endfunction

   function automatic logic m_hit(input int c);
      return m_valid[c] && m_tag[c] == cur_addr(c);
   endfunction

   function automatic logic m_miss(input int c);
      return (c == 2) ? (obj_cs && !m_hit(c)) : !m_hit(c);
   endfunction

   function automatic logic m_ok(input int c);
      return m_hit(c) && (c != 2 || obj_cs);
   endfunction

   // First missing channel after the last one served, or -1
   function automatic int m_pick();
      for (int k = 1; k <= 3; k++)
         if (m_miss((m_last + k) % 3)) return (m_last + k) % 3;
      return -1;
   endfunction

   function automatic logic [21:0] exp_sdram(input int c, input logic [17:0] a);
      logic [21:0] off;
      off = (c == 0) ? CHAR_OFF : (c == 1) ? SCR_OFF : OBJ_OFF;
      return off + {3'b000, a, 1'b0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_addr(input int c, input logic [17:0] v);
      if (c == 0)      char_addr = v[13:0];
      else if (c == 1) scr_addr  = v[16:0];
      else             obj_addr  = v;
   endtask

   task automatic check_all(input string name);
      chk({name, "_char_ok"},   32'(char_ok), 32'(m_ok(0)));
      chk({name, "_scr_ok"},    32'(scr_ok),  32'(m_ok(1)));
      chk({name, "_obj_ok"},    32'(obj_ok),  32'(m_ok(2)));
      chk({name, "_char_data"}, char_data,    m_dat[0]);
      chk({name, "_scr_data"},  scr_data,     m_dat[1]);
      chk({name, "_obj_data"},  obj_data,     m_dat[2]);
   endtask

   task automatic wait_req(input string name, input logic [21:0] exp);
      int k = 0;
      while (sdram_req !== 1'b1 && k < 32) begin
         tick();
         k++;
      end
      chk({name, "_req"},  32'(sdram_req),  32'd1);
      chk({name, "_addr"}, 32'(sdram_addr), 32'(exp));
   endtask

   task automatic give_ack(input string name, input logic [21:0] exp, input int dly);
      repeat (dly) begin
         tick();
         chk({name, "_req_hold"},  32'(sdram_req),  32'd1);
         chk({name, "_addr_hold"}, 32'(sdram_addr), 32'(exp));
      end
      sdram_ack = 1'b1;
      tick();
      sdram_ack = 1'b0;
      chk({name, "_req_drop"}, 32'(sdram_req), 32'd0);
   endtask

   task automatic give_rdy(input logic [31:0] din, input int dly);
      repeat (dly) tick();
      sdram_din = din;
      sdram_rdy = 1'b1;
      tick();
      sdram_rdy = 1'b0;
      sdram_din = $urandom;
   endtask

   // One full fetch for the channel the model says should win next
   task automatic do_fetch(input string name, input logic [31:0] din, input int ackd, input int rdyd);
      int          c;
      logic [17:0] a;
      logic [21:0] e;
      c = m_pick();
      if (c < 0) begin
         chk({name, "_model_has_miss"}, 32'd0, 32'd1);
         return;
      end
      a = cur_addr(c);
      e = exp_sdram(c, a);
      wait_req(name, e);
      give_ack(name, e, ackd);
      give_rdy(din, rdyd);
      m_valid[c] = 1'b1;
      m_tag[c]   = a;
      m_dat[c]   = din;
      m_last     = c;
      check_all(name);
   endtask

   initial begin
      logic [17:0] v;
      logic [31:0] d;
      logic [21:0] e;

      m_reset();
      char_addr = 14'h0010;
      tick();
      tick();

`ifdef JTKUNIO_GFXROM_STATS_EN
      rst = 1'b0;
      tick(); tick(); tick();
      chk("stall_3", 32'(stall_cnt), 32'd3);
      repeat (70000) tick();
      chk("stall_sat", 32'(stall_cnt), 32'h0000FFFF);
      rst = 1'b1;
      tick();
      chk("stall_clr", 32'(stall_cnt), 32'd0);
      m_reset();
`endif

      chk("rst_req",  32'(sdram_req),  32'd0);
      chk("rst_addr", 32'(sdram_addr), 32'd0);
      check_all("rst");
      rst = 1'b0;

      // First fill: char 0x10 -> SDRAM word 0x20
      do_fetch("first", 32'hDEADBEEF, 0, 0);
      chk("first_char_data", char_data, 32'hDEADBEEF);
      do_fetch("scr0", $urandom, 1, 2);

      // Object channel gated by obj_cs
      obj_addr = 18'($urandom);
      repeat (5) begin
         tick();
         chk("gate_req", 32'(sdram_req), 32'd0);
         chk("gate_ok",  32'(obj_ok),    32'd0);
      end
      obj_cs = 1'b1;
      do_fetch("gate_fill", $urandom, 0, 1);

      // All three miss together, then char alone, then char+obj
      for (int c = 0; c < 3; c++) set_addr(c, m_tag[c] ^ 18'h00155);
      do_fetch("rr_a", $urandom, 0, 0);
      do_fetch("rr_b", $urandom, 2, 0);
      do_fetch("rr_c", $urandom, 0, 3);
      set_addr(0, m_tag[0] ^ 18'h00001);
      do_fetch("rr_d", $urandom, 0, 0);
      set_addr(0, m_tag[0] ^ 18'h00002);
      set_addr(2, m_tag[2] ^ 18'h00002);
      do_fetch("rr_e", $urandom, 1, 0);
      do_fetch("rr_f", $urandom, 0, 0);

      // ack and rdy together in REQ: only the ack counts
      scr_addr = m_tag[1][16:0] ^ 17'h00010;
      v = 18'(scr_addr);
      e = exp_sdram(1, v);
      wait_req("ackrdy", e);
      sdram_ack = 1'b1;
      sdram_rdy = 1'b1;
      sdram_din = 32'h11111111;
      tick();
      sdram_ack = 1'b0;
      sdram_rdy = 1'b0;
      chk("ackrdy_req", 32'(sdram_req), 32'd0);
      check_all("ackrdy_nofill");
      tick();
      check_all("ackrdy_wait");
      d = $urandom;
      give_rdy(d, 0);
      m_valid[1] = 1'b1; m_tag[1] = v; m_dat[1] = d; m_last = 1;
      check_all("ackrdy_fill");

      // Scroll address moves while the fetch is in WAIT
      scr_addr = 17'h00100;
      wait_req("mid", SCR_OFF + 22'h200);
      give_ack("mid", SCR_OFF + 22'h200, 1);
      scr_addr = 17'h00101;
      d = $urandom;
      give_rdy(d, 1);
      m_valid[1] = 1'b1; m_tag[1] = 18'h00100; m_dat[1] = d; m_last = 1;
      check_all("mid_stale");
      do_fetch("mid_refetch", $urandom, 0, 0);
      chk("mid_refetch_tag", 32'(m_tag[1]), 32'h00101);

      // Hits are combinational and cause no traffic
      scr_addr = 17'h00100;
      #1;
      chk("hit_miss_now", 32'(scr_ok), 32'd0);
      scr_addr = 17'h00101;
      #1;
      chk("hit_now", 32'(scr_ok), 32'd1);
      repeat (3) begin
         tick();
         chk("hit_no_req", 32'(sdram_req), 32'd0);
      end

      // Reset while waiting for data; a late rdy must be ignored
      char_addr = m_tag[0][13:0] ^ 14'h0100;
      v = 18'(char_addr);
      e = exp_sdram(0, v);
      wait_req("rstmid", e);
      give_ack("rstmid", e, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_reset();
      chk("rstmid_req",  32'(sdram_req),  32'd0);
      chk("rstmid_addr", 32'(sdram_addr), 32'd0);
      check_all("rstmid");
      sdram_rdy = 1'b1;
      sdram_din = 32'hBADBAD00;
      tick();
      sdram_rdy = 1'b0;
      check_all("rstmid_stale_rdy");
      do_fetch("rstmid_r0", $urandom, 0, 0);
      do_fetch("rstmid_r1", $urandom, 0, 0);
      do_fetch("rstmid_r2", $urandom, 0, 0);

      // Randomized rounds
      for (int r = 0; r < 25; r++) begin
         for (int c = 0; c < 3; c++) begin
            int sel;
            sel = $urandom_range(3);
            if (sel < 2)       set_addr(c, 18'($urandom));
            else if (sel == 2) set_addr(c, m_tag[c]);
         end
         obj_cs = 1'($urandom);
         if (m_pick() < 0) begin
            tick();
            chk("rnd_idle_req", 32'(sdram_req), 32'd0);
            check_all("rnd_idle");
         end else begin
            for (int k = 0; k < 4 && m_pick() >= 0; k++)
               do_fetch("rnd", $urandom, $urandom_range(3), $urandom_range(3));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
